// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with synchronous clear/load, terminal-count flag, wrap pulse and sticky overflow.
// Define LIBSV_MOD_UPDOWN_COUNTER_SATURATE_EN to saturate at the terminal count instead of wrapping.
module mod_updown_counter #(
  parameter int unsigned N   = 8,
  parameter int unsigned MOD = 2**N
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap,
  output logic         ovf
);

  // One extra bit so MOD == 2**N compares without truncation.
  localparam int unsigned W       = N + 1;
  localparam logic [W-1:0] MAX_EXT = W'(MOD - 1);
  localparam logic [N-1:0] QMAX    = N'(MOD - 1);

  logic [W-1:0] q_ext;
  logic [W-1:0] d_ext;
  logic         at_max;
  logic         at_min;
  logic [N-1:0] up_tc_val;
  logic [N-1:0] dn_tc_val;
  logic [N-1:0] q_next;

  assign q_ext  = {1'b0, q};
  assign d_ext  = {1'b0, d};
  assign at_max = (q_ext == MAX_EXT);
  assign at_min = (q == '0);
  assign tc     = en & ~clr & ~load & ((up & at_max) | (~up & at_min));

`ifdef LIBSV_MOD_UPDOWN_COUNTER_SATURATE_EN
  assign up_tc_val = QMAX;
  assign dn_tc_val = '0;
`else
  assign up_tc_val = '0;
  assign dn_tc_val = QMAX;
`endif

  // Next count: clr > load > en, hold otherwise.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = (d_ext > MAX_EXT) ? QMAX : d;
    end else if (en) begin
      if (up) begin
        q_next = at_max ? up_tc_val : q + N'(1);
      end else begin
        q_next = at_min ? dn_tc_val : q - N'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= tc;
      if (clr) begin
        ovf <= 1'b0;
      end else if (tc) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: two counters (MOD=10 and MOD=16, N=4) share randomized and directed stimulus.
// A modulo-arithmetic reference model predicts each cycle; a monitor process pops and compares.
module tb_mod_updown_counter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         clr = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] d = '0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [N-1:0] q0, q1;
  logic         tc0, tc1, wrap0, wrap1, ovf0, ovf1;

  mod_updown_counter #(.N(N), .MOD(10)) dut0 (
    .clk(clk), .areset(areset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q0), .tc(tc0), .wrap(wrap0), .ovf(ovf0)
  );

  mod_updown_counter #(.N(N), .MOD(16)) dut1 (
    .clk(clk), .areset(areset), .clr(clr), .load(load), .d(d), .en(en), .up(up),
    .q(q1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tc;
    int q;
    int w;
    int o;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

`ifdef LIBSV_MOD_UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int mods[2] = '{10, 16};
  int mq[2];
  int mw[2];
  int mo[2];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input int inst, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, inst, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mw[i] = 0; mo[i] = 0;
    end
  endfunction

  // Advance the reference model one edge for instance i, returning the expected record.
  function automatic exp_t model_step(input int i);
    exp_t e;
    int m;
    int t;
    m = mods[i];
    t = (en && !clr && !load && ((up && mq[i] == m - 1) || (!up && mq[i] == 0))) ? 1 : 0;
    if (clr) mq[i] = 0;
    else if (load) mq[i] = (int'(d) > m - 1) ? m - 1 : int'(d);
    else if (en) begin
      if (t == 1 && SAT) mq[i] = mq[i];
      else if (up) mq[i] = (mq[i] + 1) % m;
      else mq[i] = (mq[i] + m - 1) % m;
    end
    mw[i] = t;
    mo[i] = clr ? 0 : (mo[i] | t);
    e.tc = t; e.q = mq[i]; e.w = mw[i]; e.o = mo[i];
    return e;
  endfunction

  // One stimulus cycle: drive at negedge, push expectations.
  task automatic cyc(input logic c, input logic l, input logic [N-1:0] dv, input logic e, input logic u);
    @(negedge clk);
    clr = c; load = l; d = dv; en = e; up = u;
    sb0.push_back(model_step(0));
    sb1.push_back(model_step(1));
  endtask

  // Asynchronous reset mid-cycle with a load and count pending.
  task automatic do_reset(input logic [N-1:0] pend);
    @(negedge clk);
    clr = 1'b0; load = 1'b1; d = pend; en = 1'b1; up = 1'b1;
    #2 areset = 1'b1;
    #1;
    chk("async_q", 0, int'(q0), 0);   chk("async_q", 1, int'(q1), 0);
    chk("async_wrap", 0, int'(wrap0), 0); chk("async_ovf", 0, int'(ovf0), 0);
    chk("async_wrap", 1, int'(wrap1), 0); chk("async_ovf", 1, int'(ovf1), 0);
    @(negedge clk);
    chk("rst_hold_q", 0, int'(q0), 0); chk("rst_hold_q", 1, int'(q1), 0);
    areset = 1'b0; load = 1'b0; en = 1'b0;
    model_reset();
  endtask

  // Monitor: combinational tc before the edge, registered outputs after it.
  initial begin
    int tc_s0, tc_s1;
    bit have;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      have = (sb0.size() > 0) && (sb1.size() > 0);
      tc_s0 = int'(tc0); tc_s1 = int'(tc1);
      @(posedge clk);
      #1;
      if (have && !areset) begin
        e = sb0.pop_front();
        chk("tc", 0, tc_s0, e.tc); chk("q", 0, int'(q0), e.q);
        chk("wrap", 0, int'(wrap0), e.w); chk("ovf", 0, int'(ovf0), e.o);
        e = sb1.pop_front();
        chk("tc", 1, tc_s1, e.tc); chk("q", 1, int'(q1), e.q);
        chk("wrap", 1, int'(wrap1), e.w); chk("ovf", 1, int'(ovf1), e.o);
      end
    end
  end

  initial begin
    int waited;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_q", 0, int'(q0), 0); chk("reset_ovf", 0, int'(ovf0), 0);
    chk("reset_wrap", 0, int'(wrap0), 0); chk("reset_tc", 0, int'(tc0), 0);
    areset = 1'b0;

    // Count up 12 cycles from 0, then wrap/saturate.
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 1);
    // Down from 0.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Load clamp, then load overrides a terminal count.
    cyc(0, 1, 4'd13, 0, 1);
    cyc(0, 1, 4'd4, 1, 1);
    // Full-range terminal count on the MOD=16 instance.
    cyc(0, 1, 4'd15, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // clr beats load and en while ovf is set.
    cyc(0, 1, 4'd9, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 1, 4'd5, 1, 1);
    cyc(0, 0, 0, 0, 1);
    // Async reset mid-count at q=7.
    cyc(0, 1, 4'd7, 0, 1);
    repeat (3) @(negedge clk);
    do_reset(4'd3);
    cyc(0, 0, 0, 1, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        repeat (3) @(negedge clk);
        do_reset(4'($urandom_range(0, 15)));
      end else begin
        cyc(logic'($urandom_range(0, 99) < 4),
            logic'($urandom_range(0, 99) < 12),
            4'($urandom_range(0, 15)),
            logic'($urandom_range(0, 99) < 80),
            logic'($urandom_range(0, 1)));
      end
    end

    @(negedge clk);
    clr = 0; load = 0; en = 0;
    waited = 0;
    while ((sb0.size() > 0 || sb1.size() > 0) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (sb0.size() > 0 || sb1.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations never checked", sb0.size(), sb1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 SHALL have parameter N, default 8: counter width in bits, N >= 1.
REQ-002 SHALL have parameter MOD, default 2**N: count modulus, legal range 2 .. 2**N; the legal count range is 0 .. MOD-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous clear to 0, highest synchronous priority.
REQ-006 SHALL have port load  input  1  synchronous parallel load of d.
REQ-007 SHALL have port d  input  N  load value.
REQ-008 SHALL have port en  input  1  count enable.
REQ-009 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-010 SHALL have port q  output  N  registered count value.
REQ-011 SHALL have port tc  output  1  combinational terminal-count flag: a wrap or saturation will occur on the next edge.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle after a terminal-count event.
REQ-013 SHALL have port ovf  output  1  registered sticky flag, set by any terminal-count event.

Function
REQ-014 SHALL apply the synchronous priority clr > load > en each cycle; when clr, load and en are all 0, q SHALL hold.
REQ-015 SHALL on clr set q=0, ovf=0, wrap=0 at the next edge.
REQ-016 SHALL on load (clr=0) set q=d when d <= MOD-1, else q=MOD-1 (clamp); ovf SHALL be unchanged and wrap=0.
REQ-017 SHALL on en=1, up=1 (no clr/load) set q=q+1 when q < MOD-1; at q=MOD-1, q SHALL go to 0 (wrap mode).
REQ-018 SHALL on en=1, up=0 (no clr/load) set q=q-1 when q > 0; at q=0, q SHALL go to MOD-1 (wrap mode).
REQ-019 SHALL drive tc = en & ~clr & ~load & ((up & q==MOD-1) | (~up & q==0)), with zero cycles of latency.
REQ-020 SHALL register wrap <= tc each edge, so wrap is high for exactly one cycle after each tc cycle.
REQ-021 SHALL set ovf at the edge where tc=1 and hold it until clr or areset; load SHALL NOT clear ovf.
REQ-022 SHALL perform the MOD-1 comparison at N+1 bits internally, so that MOD=2**N is legal without truncation.
REQ-023 SHALL keep q within 0 .. MOD-1 under all input sequences after reset.
REQ-024 SHALL allow a direction change on any cycle, with no extra latency.

Reset
REQ-025 SHALL on areset=1 immediately force q=0, wrap=0 and ovf=0, independent of clk.
REQ-026 SHALL resume counting on the first rising edge after areset deasserts, honouring the inputs of that cycle.
REQ-027 SHALL, when areset asserts mid-operation, abandon any pending load or count; the flags SHALL show no event.

Configuration
REQ-028 SHALL support the macro LIBSV_MOD_UPDOWN_COUNTER_SATURATE_EN.
REQ-029 SHALL, with the macro defined, saturate on a terminal count: up holds q=MOD-1, down holds q=0; tc, wrap and ovf SHALL behave as in REQ-019 to REQ-021.
REQ-030 SHALL, with the macro undefined, wrap as in REQ-017 and REQ-018; all other behaviour SHALL be identical.

Verification (N=4, MOD=10)
REQ-031 SHALL cover: areset pulse mid-count with q=7 -> q=0, ovf=0 and wrap=0 immediately, with no clk edge needed.
REQ-032 SHALL cover: en=1, up=1 for 12 cycles from q=0 -> q sequence 1..9,0,1,2; tc high only while q=9; wrap high the cycle after; ovf=1 thereafter (saturate build: q holds at 9).
REQ-033 SHALL cover: en=1, up=0 from q=0 -> tc=1, next q=9 with wrap=1 (saturate build: q stays 0).
REQ-034 SHALL cover: load=1 with d=13 -> q=9; load=1 with d=4 while en=1 and q=9 -> q=4 and tc=0.
REQ-035 SHALL cover: clr=1 together with load=1 and en=1 while ovf=1 -> q=0, ovf=0, wrap=0.
REQ-036 SHALL cover: MOD=16 with en=1, up=1 from q=15 -> q=0 with tc=1, proving the full-range comparison.
